// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the core's data-memory store port
// and a slower data memory with a valid/ready write interface.
//
// Stores are pushed in core issue order and drained oldest-first. A load
// lookup (rd_adr) is answered combinationally from any occupied entry with the
// same word address; the youngest such entry wins. When the buffer is full the
// core is stalled, and that stall depends only on registered state.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [AW-1:0]              dataadr,
    input  logic [DW-1:0]              writedata,
    input  logic [AW-1:0]              rd_adr,
    output logic                       rd_hit,
    output logic [DW-1:0]              rd_data,
    output logic                       stall,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [AW-1:0]              mem_adr,
    output logic [DW-1:0]              mem_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Entry storage and bookkeeping
    logic [AW-1:0] adr_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic push;
    logic pop;

    // Byte-offset bits of the load address take no part in the word compare.
    logic unused_rd_offset;
    assign unused_rd_offset = ^rd_adr[1:0];

    // Status and handshake derived purely from registered state.
    assign empty     = (count_q == CNT_ZERO);
    assign stall     = (count_q == CNT_FULL);
    assign count     = count_q;
    assign mem_valid = !empty;

    // A full buffer refuses the store even if memory drains this same cycle;
    // the core simply re-presents it next cycle.
    assign push = memwrite && !stall;
    assign pop  = mem_valid && mem_ready;

    // Head entry is presented to memory; forced to zero while empty so stale
    // entry contents never show on the memory port.
    assign mem_adr   = empty ? '0 : adr_q[head_q];
    assign mem_wdata = empty ? '0 : data_q[head_q];

    // Pointer, count and valid-bit update; reset discards all pending stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_ONE;
            end
            // push and pop never target the same slot: equal pointers only
            // occur when empty (no pop) or full (no push).
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload write on push.
    // NOTE: the payload array has no reset; occupancy is tracked by vld_q and
    // count_q, so reset values here would cost logic without changing behaviour.
    always_ff @(posedge clk) begin
        if (push) begin
            adr_q[tail_q]  <= dataadr;
            data_q[tail_q] <= writedata;
        end
    end

    // Forwarding lookup: walk entries from oldest to youngest so the last
    // matching occupied entry (nearest the tail) supplies the data.
    always_comb begin
        logic [PW-1:0] idx;
        // NOTE: every output gets a default before the loop; without it a
        // no-hit path would leave rd_hit/rd_data unassigned and infer a latch.
        rd_hit  = 1'b0;
        rd_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (vld_q[idx] && (adr_q[idx][AW-1:2] == rd_adr[AW-1:2])) begin
                rd_hit  = 1'b1;
                rd_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a scoreboard queue holds the stores the
// bench expects to be accepted; entries are popped and compared when the DUT
// hands its head entry to memory. Forwarding and status are checked each cycle
// against the same queue.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            reset;
    logic            memwrite;
    logic [AW-1:0]   dataadr;
    logic [DW-1:0]   writedata;
    logic [AW-1:0]   rd_adr;
    logic            rd_hit;
    logic [DW-1:0]   rd_data;
    logic            stall;
    logic            mem_valid;
    logic            mem_ready;
    logic [AW-1:0]   mem_adr;
    logic [DW-1:0]   mem_wdata;
    logic [CW-1:0]   count;
    logic            empty;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .rd_adr    (rd_adr),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .stall     (stall),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t sb[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare settled
    // outputs with the scoreboard, then advance the model at the rising edge.
    task automatic step(input logic rst, input logic mw, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat, input logic rdy, input logic [AW-1:0] radr);
        logic          exp_hit;
        logic [DW-1:0] exp_rd;
        int            n;
        logic          do_push;
        logic          do_pop;
        entry_t        e;
        @(negedge clk);
        reset     = rst;
        memwrite  = mw;
        dataadr   = adr;
        writedata = dat;
        mem_ready = rdy;
        rd_adr    = radr;
        #1;
        n = sb.size();
        exp_hit = 1'b0;
        exp_rd  = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!exp_hit && sb[i].adr[AW-1:2] == radr[AW-1:2]) begin
                exp_hit = 1'b1;
                exp_rd  = sb[i].data;
            end
        end
        check("count", 64'(count), 64'(n));
        check("empty", 64'(empty), 64'(n == 0));
        check("stall", 64'(stall), 64'(n == DEPTH));
        check("mem_valid", 64'(mem_valid), 64'(n != 0));
        check("mem_adr", 64'(mem_adr), 64'((n != 0) ? sb[0].adr : '0));
        check("rd_hit", 64'(rd_hit), 64'(exp_hit));
        check("rd_data", 64'(rd_data), 64'(exp_rd));
        do_push = mw && (n < DEPTH);
        do_pop  = rdy && (n != 0);
        if (do_pop) begin
            e = sb.pop_front();
            check("drain_wdata", 64'(mem_wdata), 64'(e.data));
        end
        if (rst) begin
            sb.delete();
        end else if (do_push) begin
            e.adr  = adr;
            e.data = dat;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic rdy, input logic [AW-1:0] radr);
        step(1'b0, 1'b0, '0, '0, rdy, radr);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 2 * DEPTH + 2; i++) idle(1'b1, 32'h0);
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        mem_ready = 1'b0; rd_adr = '0;

        // Reset, then confirm reset state (no mem_valid in first cycle after).
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b1, 32'd40, 32'h5, 1'b1, '0);
        idle(1'b0, 32'd80);

        // Single store, held with mem_ready low, then accepted.
        step(1'b0, 1'b1, 32'd80, 32'h0000_0226, 1'b0, 32'd80);
        idle(1'b0, 32'd80);
        idle(1'b0, 32'd80);
        idle(1'b1, 32'd80);
        idle(1'b0, 32'd80);

        // Fill to full, fifth store held, one mem_ready pulse frees a slot.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(80 + 4 * i), 32'(32'hA0 + i), 1'b0, 32'd88);
        step(1'b0, 1'b1, 32'd96, 32'hA4, 1'b0, 32'd96);
        step(1'b0, 1'b1, 32'd96, 32'hA4, 1'b0, 32'd96);
        step(1'b0, 1'b1, 32'd96, 32'hA4, 1'b1, 32'd96);
        step(1'b0, 1'b1, 32'd96, 32'hA4, 1'b0, 32'd96);
        idle(1'b0, 32'd96);
        drain_all();

        // Forwarding: youngest match wins, byte offset ignored, miss gives 0.
        step(1'b0, 1'b1, 32'd80, 32'h11, 1'b0, 32'd80);
        step(1'b0, 1'b1, 32'd84, 32'h22, 1'b0, 32'd80);
        step(1'b0, 1'b1, 32'd80, 32'h33, 1'b0, 32'd80);
        idle(1'b0, 32'd80);
        idle(1'b0, 32'd82);
        idle(1'b0, 32'd88);
        idle(1'b0, 32'd84);
        idle(1'b1, 32'd80);
        drain_all();

        // Simultaneous push/pop at count 2 across pointer wrap.
        step(1'b0, 1'b1, 32'd80, 32'h100, 1'b0, 32'd80);
        step(1'b0, 1'b1, 32'd84, 32'h101, 1'b0, 32'd80);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 32'(88 + 4 * k), 32'(32'h102 + k), 1'b1, 32'(84 + 4 * k));
        drain_all();

        // Reset with three pending stores discards them.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'(80 + 4 * i), 32'(32'h200 + i), 1'b0, 32'd80);
        step(1'b1, 1'b0, '0, '0, 1'b0, 32'd80);
        idle(1'b0, 32'd80);
        idle(1'b1, 32'd80);

        // Program store stream result: 50 <- 0 drained exactly once.
        step(1'b0, 1'b1, 32'd50, 32'h0, 1'b0, 32'd50);
        idle(1'b1, 32'd50);
        idle(1'b1, 32'd50);
        idle(1'b1, 32'd50);

        // Random mix on a small address set to stress forwarding and ordering.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 5) + $urandom_range(0, 3)),
                 $urandom, 1'($urandom_range(0, 2) == 0), 32'(4 * $urandom_range(0, 5) + $urandom_range(0, 3)));
        end
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
